bht_predictor: RTL and testbench
================================

Name: bht_predictor

Overview:
- Branch history table that predicts conditional-branch direction for the fetch stage, upstream of branch_unit.
- It is trained from branch outcomes resolved in execute.
- Each entry holds a valid bit and a 2-bit saturating counter, indexed by PC bits.
- The table is cleared by a one-entry-per-cycle init sweep so the array can later map onto single-port SRAM.

Parameters:
- NR_ENTRIES, 256, number of table entries; power of 2, at least 4.
- INDEX_LSB, 1, lowest PC bit used for the index; 1 supports compressed instructions.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  restarts the init sweep; clears all learned state.
- query_valid_i  in  1  fetch requests a prediction.
- query_pc_i  in  riscv::VLEN  PC being fetched.
- pred_valid_o  out  1  prediction available; registered.
- pred_taken_o  out  1  predicted direction; registered.
- update_valid_i  in  1  resolved conditional branch.
- update_pc_i  in  riscv::VLEN  PC of the resolved branch.
- update_taken_i  in  1  actual branch outcome.
- init_busy_o  out  1  init sweep in progress.

Behaviour:
- Index: idx = pc[INDEX_LSB +: log2(NR_ENTRIES)]. No tag; aliasing is accepted.
- FSM states: INIT and READY.
- Reset response: rst_i forces state = INIT, sweep_cnt = 0, pred_valid_o = 0, pred_taken_o = 0 on the next edge. init_busy_o = 1 whenever state = INIT.
- INIT, each cycle:
  - Entry[sweep_cnt] is written with valid = 0, ctr = 2'b01 (weakly not-taken).
  - sweep_cnt increments.
  - When sweep_cnt = NR_ENTRIES-1 is written, the next state is READY.
  - Init takes exactly NR_ENTRIES cycles.
- flush_i:
  - From any state, the next state is INIT with sweep_cnt = 0.
  - flush_i during INIT restarts the sweep from 0.
  - rst_i has priority over flush_i.
- Query latency is 1 cycle:
  - If query_valid_i in cycle N, in cycle N+1: pred_valid_o = entry.valid, pred_taken_o = entry.ctr[1].
  - A query in INIT, or no query, yields pred_valid_o = 0, pred_taken_o = 0 in N+1.
  - A query in the cycle flush_i is asserted yields pred_valid_o = 0 in N+1.
- Update, in READY only; updates during INIT are dropped silently:
  - The entry gets valid = 1.
  - If taken, ctr = sat(ctr+1); 2'b11 stays 2'b11.
  - If not taken, ctr = sat(ctr-1); 2'b00 stays 2'b00.
  - The update is visible to queries issued the cycle after it.
- Simultaneous query and update to the same index: the query returns the pre-update value (read-before-write).
- Update with flush_i in the same cycle: the update is dropped.
- Single write port: an update and a sweep write never coincide, by FSM construction.
- No backpressure: fetch may query every cycle, execute may update every cycle.

Decomposition:
- Add bht_entry_t {valid, ctr[1:0]} to ariane_pkg, next to branchpredict_sbe_t, so the frontend can reuse it.
- Add bht_state_e {INIT, READY} to ariane_pkg.
- Table storage, index extraction and the FSM live in bht_predictor.
- Sub-module sat_counter2 is the pure-combinational 2-bit saturating up/down function. It is shared with the future BTB hysteresis bits.

Test Plan:
- Reset and init: assert rst_i 1 cycle → init_busy_o = 1 for exactly 256 cycles, then 0. A query at cycle 10 gives pred_valid_o = 0. A query after READY at PC 0x80000000 gives valid = 0, taken = 0.
- Saturation: 3 taken updates to PC 0x1004 → ctr goes 01→10→11→11. A query at 0x1004 gives valid = 1, taken = 1. Then 4 not-taken updates → ctr 00, taken = 0.
- Aliasing and index: an update at 0x1004 is visible at PC 0x1004 + 0x200. With NR_ENTRIES = 256, INDEX_LSB = 1 these alias. PC 0x1006 is unaffected (valid = 0).
- Read-before-write: query and taken update to idx 5 in the same cycle with ctr = 01 → pred_taken_o = 0 next cycle. The following query gives 1.
- Flush mid-operation: train entry 7 to 11, assert flush_i at sweep midpoint of a second flush → sweep restarts, 256 more cycles busy. Updates during INIT are ignored. Entry 7 then reads valid = 0.
- Priority: rst_i and flush_i together with update_valid_i at idx 3 → state INIT, sweep_cnt = 0, idx 3 is not trained after init completes.

Source files
------------

// File: rtl/bht_predictor_pkg.sv
// bht_predictor_pkg: shared types and constants for the branch history table.
// Contents:
//   VLEN            virtual address width of the PCs fed to the predictor
//   bht_entry_t     one table entry: valid bit plus 2-bit saturating counter
//   bht_state_e     table FSM states (INIT sweep, READY for use)
//   BHT_ENTRY_INIT  value written by the init sweep (invalid, weakly not-taken)
package bht_predictor_pkg;

    localparam int VLEN = 64;

    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } bht_entry_t;

    typedef enum logic {
        INIT,
        READY
    } bht_state_e;

    localparam bht_entry_t BHT_ENTRY_INIT = '{valid: 1'b0, ctr: 2'b01};

endpackage

// File: rtl/bht_predictor_sat.sv
// sat_counter2: combinational 2-bit saturating up/down counter step.
// Ports:
//   i_ctr  current counter value
//   i_up   1 = count up (saturate at 2'b11), 0 = count down (saturate at 2'b00)
//   o_ctr  next counter value
module sat_counter2 (
    input  logic [1:0] i_ctr,
    input  logic       i_up,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_up ? ((i_ctr == 2'b11) ? i_ctr : i_ctr + 2'b01)
                     : ((i_ctr == 2'b00) ? i_ctr : i_ctr - 2'b01);
    end

endmodule

// File: rtl/bht_predictor.sv
// bht_predictor: PC-indexed branch history table with a one-entry-per-cycle init sweep.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   flush_i                         restart the init sweep, discarding learned state
//   query_valid_i, query_pc_i       prediction request from fetch
//   pred_valid_o, pred_taken_o      registered prediction, one cycle after the query
//   update_valid_i, update_pc_i,
//   update_taken_i                  resolved conditional branch from execute
//   init_busy_o                     high while the init sweep runs
module bht_predictor
    import bht_predictor_pkg::*;
#(
    parameter int NR_ENTRIES = 256,
    parameter int INDEX_LSB  = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            query_valid_i,
    input  logic [VLEN-1:0] query_pc_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o,
    input  logic            update_valid_i,
    input  logic [VLEN-1:0] update_pc_i,
    input  logic            update_taken_i,
    output logic            init_busy_o
);

    localparam int IDX_W = $clog2(NR_ENTRIES);

    bht_state_e       r_state;
    logic [IDX_W-1:0] r_sweep_cnt;
    logic             r_pred_valid;
    logic             r_pred_taken;
    bht_entry_t       r_table [NR_ENTRIES];

    logic [IDX_W-1:0] w_qidx;
    logic [IDX_W-1:0] w_uidx;
    logic [1:0]       w_upd_ctr;
    logic             w_we;
    logic [IDX_W-1:0] w_widx;
    bht_entry_t       w_wdata;
    logic             w_unused;

    assign w_qidx   = query_pc_i[INDEX_LSB +: IDX_W];
    assign w_uidx   = update_pc_i[INDEX_LSB +: IDX_W];
    // PC bits outside the index field are intentionally ignored (no tag).
    assign w_unused = ^{query_pc_i, update_pc_i};

    sat_counter2 u_sat (
        .i_ctr (r_table[w_uidx].ctr),
        .i_up  (update_taken_i),
        .o_ctr (w_upd_ctr)
    );

    // Single write port: the sweep owns it in INIT, updates own it in READY.
    always_comb begin
        w_we    = !rst_i && !flush_i && (r_state == INIT || update_valid_i);
        w_widx  = (r_state == INIT) ? r_sweep_cnt : w_uidx;
        w_wdata = (r_state == INIT) ? BHT_ENTRY_INIT : bht_entry_t'{1'b1, w_upd_ctr};
    end

    always_ff @(posedge clk_i) begin
        if (w_we) r_table[w_widx] <= w_wdata;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= INIT;
            r_sweep_cnt  <= '0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
        end else begin
            // Read happens before this edge's table write, giving read-before-write.
            r_pred_valid <= query_valid_i && !flush_i && r_state == READY && r_table[w_qidx].valid;
            r_pred_taken <= query_valid_i && !flush_i && r_state == READY && r_table[w_qidx].ctr[1];
            if (flush_i) begin
                r_state     <= INIT;
                r_sweep_cnt <= '0;
            end else if (r_state == INIT) begin
                r_sweep_cnt <= r_sweep_cnt + IDX_W'(1);
                if (r_sweep_cnt == IDX_W'(NR_ENTRIES - 1)) r_state <= READY;
            end
        end
    end

    assign pred_valid_o = r_pred_valid;
    assign pred_taken_o = r_pred_taken;
    assign init_busy_o  = (r_state == INIT);

endmodule

// File: tb/tb_bht_predictor.sv
// tb_bht_predictor: directed scoreboard bench for bht_predictor.
module tb_bht_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        query_valid_i = 1'b0;
    logic [63:0] query_pc_i = '0;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic        update_valid_i = 1'b0;
    logic [63:0] update_pc_i = '0;
    logic        update_taken_i = 1'b0;
    logic        init_busy_o;

    int checks = 0;
    int failures = 0;
    logic [1:0] exp_q [$];

    bht_predictor dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .query_valid_i  (query_valid_i),
        .query_pc_i     (query_pc_i),
        .pred_valid_o   (pred_valid_o),
        .pred_taken_o   (pred_taken_o),
        .update_valid_i (update_valid_i),
        .update_pc_i    (update_pc_i),
        .update_taken_i (update_taken_i),
        .init_busy_o    (init_busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: a query seen at an edge owns the prediction shown after that edge.
    initial begin
        logic pend;
        logic [1:0] e;
        forever begin
            @(posedge clk_i);
            pend = query_valid_i;
            @(negedge clk_i);
            if (pend) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pred_unexpected got valid=%0b taken=%0b with no expectation queued", pred_valid_o, pred_taken_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({pred_valid_o, pred_taken_o} !== e) begin
                        failures++;
                        $display("FAIL pred got valid=%0b taken=%0b want valid=%0b taken=%0b", pred_valid_o, pred_taken_o, e[1], e[0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // One cycle of stimulus, entered and left at a falling edge.
    task automatic cyc(input bit q, input logic [63:0] qpc, input bit ev, input bit et,
                       input bit u, input logic [63:0] upc, input bit ut,
                       input bit fl, input bit rs);
        query_valid_i  = q;
        query_pc_i     = qpc;
        update_valid_i = u;
        update_pc_i    = upc;
        update_taken_i = ut;
        flush_i        = fl;
        rst_i          = rs;
        if (q) exp_q.push_back({ev, et});
        @(negedge clk_i);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic query(input logic [63:0] pc, input bit ev, input bit et);
        cyc(1, pc, ev, et, 0, 0, 0, 0, 0);
    endtask

    task automatic update(input logic [63:0] pc, input bit t);
        cyc(0, 0, 0, 0, 1, pc, t, 0, 0);
    endtask

    // Count busy cycles of an init sweep, optionally querying / updating on given iterations.
    task automatic measure_init(input int qk, input int uk, input logic [63:0] upc, input int exp_n);
        int n = 0;
        while (init_busy_o && n < 1000) begin
            cyc(n == qk, 64'h0, 0, 0, n == uk, upc, 1, 0, 0);
            n++;
        end
        check("init_len", n, exp_n);
    endtask

    initial begin
        @(negedge clk_i);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_pred_valid", int'(pred_valid_o), 0);
        check("rst_pred_taken", int'(pred_taken_o), 0);
        check("rst_busy", int'(init_busy_o), 1);
        measure_init(10, -1, 0, 256);
        check("ready_busy", int'(init_busy_o), 0);
        query(64'h8000_0000, 0, 0);

        // Saturation up: idx 2 goes 01->10->11->11
        update(64'h1004, 1);
        query(64'h1004, 1, 1);
        update(64'h1004, 1);
        update(64'h1004, 1);
        query(64'h1004, 1, 1);
        query(64'h1204, 1, 1);
        query(64'h1006, 0, 0);
        // Saturation down: 11->10->01->00->00, then one taken lands on 01
        update(64'h1004, 0);
        update(64'h1004, 0);
        update(64'h1004, 0);
        update(64'h1004, 0);
        query(64'h1004, 1, 0);
        update(64'h1004, 1);
        query(64'h1004, 1, 0);

        // Read-before-write on idx 5
        cyc(1, 64'h000A, 0, 0, 1, 64'h000A, 1, 0, 0);
        query(64'h000A, 1, 1);

        // Flush restart: train idx 7 to 11, flush, re-flush at midpoint
        update(64'h000E, 1);
        update(64'h000E, 1);
        query(64'h000E, 1, 1);
        cyc(1, 64'h000E, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 128; k++) idle();
        check("mid_busy", int'(init_busy_o), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        measure_init(20, 200, 64'h000E, 256);
        query(64'h000E, 0, 0);
        query(64'h1004, 0, 0);

        // Reset + flush + update together; the query in that cycle sees reset
        update(64'h1004, 1);
        query(64'h1004, 1, 1);
        cyc(1, 64'h1004, 0, 0, 1, 64'h0006, 1, 1, 1);
        check("prio_busy", int'(init_busy_o), 1);
        measure_init(-1, -1, 0, 256);
        query(64'h0006, 0, 0);
        query(64'h1004, 0, 0);

        idle();
        idle();
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
